access_sequencer: RTL and testbench
===================================

// Module: access_sequencer
// PURPOSE
//  Central sequencer for the security system: decides which VGA source (camera or touchscreen GUI) is
//  shown, drives the door motor enable, and enforces a failed-attempt lockout. Consumes camera
//  verdicts (unlock/cam_done), touchscreen slave word and the GUI request button; replaces the ad-hoc
//  two-state display select in the top level. Outputs feed the VGA mux, the motor block and the touchscreen.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000      gui_req_n must be stable this many cycles to register a press (20 ms)
//  OPEN_CYCLES      250_000_000    cycles motor_open stays high per grant (5 s)
//  LOCK_CYCLES      1_500_000_000  cycles spent in LOCKOUT (30 s); counter width = $clog2(max(OPEN,LOCK)+1)
//  MAX_FAILS        3              consecutive failures (camera or PIN) that trigger LOCKOUT; range 1..7
// PORTS
//  CLOCK_50    in   1   system clock, 50 MHz; all logic on posedge
//  KEY0        in   1   synchronous active-low reset (board KEY[0])
//  gui_req_n   in   1   raw GUI request button (KEY[2]), active-low, asynchronous: 2-FF sync then debounce
//  unlock      in   1   camera verdict, valid when cam_done high
//  cam_done    in   1   camera verification done (level or pulse; rising edge is the event)
//  ts_cmd      in   32  touchscreen slave word; bit4 exit GUI, bit5 PIN accepted, bit6 PIN rejected
//  gui_select  out  1   1 = GUI drives VGA, 0 = camera drives VGA (registered)
//  motor_open  out  1   door motor enable (registered)
//  lockout     out  1   high while in LOCKOUT (registered)
//  fail_cnt    out  3   consecutive failure count (registered)
//  state_code  out  3   current state encoding, for HEX/LED debug
//  in_c_sig    out  3   {cam_done, unlock, gui_select} status word to touchscreen (combinational concat)
// BEHAVIOUR
//  Reset (KEY0=0 at a clock edge): state=CAM, all outputs 0, counters 0, sync/edge regs cleared; reset
//   mid-OPEN or mid-LOCKOUT aborts immediately (motor_open=0 next cycle). Lockout NOT persistent.
//  Events are rising edges, detected against previous-cycle value: cam_done, ts_cmd[4], [5], [6].
//   Press = debounced gui_req_n 1->0 transition. Event acts on the cycle after the edge is sampled.
//  States (state_code): CAM=0, GUI=1, OPEN=2, LOCKOUT=3; 4..7 unused -> CAM.
//  CAM: gui_select=0. cam_done edge with unlock=1 -> OPEN, fail_cnt<=0. cam_done edge with unlock=0
//   -> fail_cnt+1; if new value == MAX_FAILS -> LOCKOUT else stay. Press -> GUI. cam_done edge
//   and press same cycle: cam_done wins (press dropped). ts_cmd events ignored.
//  GUI: gui_select=1. ts[5] -> OPEN, fail_cnt<=0, gui_select<=0. ts[6] -> fail_cnt+1, LOCKOUT at
//   MAX_FAILS (gui_select<=0) else stay. ts[4] -> CAM. Priority same cycle: ts[5] > ts[6] > ts[4].
//   cam_done edges and presses ignored.
//  OPEN: motor_open=1, gui_select=0; timer loads OPEN_CYCLES-1 on entry, decrements each cycle;
//   at 0 -> CAM, motor_open<=0. motor_open high for exactly OPEN_CYCLES cycles. All events ignored.
//  LOCKOUT: lockout=1, gui_select=0, motor_open=0; timer runs LOCK_CYCLES cycles, then -> CAM with
//   fail_cnt<=0, lockout<=0. All events ignored (edges occurring during LOCKOUT are not queued).
//  fail_cnt saturates at MAX_FAILS; never wraps.
//  Outputs change only on clock edges except in_c_sig bits 2:1 (pass-through).
// TESTING  (bench params: DEBOUNCE=4, OPEN=8, LOCK=16, MAX_FAILS=3)
//  Reset: hold KEY0=0 3 cycles -> gui_select=0, motor_open=0, lockout=0, fail_cnt=0, state_code=0.
//  Grant: cam_done pulse with unlock=1 -> state_code=2, motor_open high exactly 8 cycles, then state 0.
//  Lockout: 3 cam_done pulses unlock=0 -> fail_cnt 1,2,3; lockout=1 for 16 cycles; then fail_cnt=0, state 0.
//  GUI: gui_req_n low 6 cycles -> gui_select=1; 2-cycle glitch -> no change; ts_cmd[4] rise -> gui_select=0.
//  Priority: in GUI, ts_cmd[6:4]=3'b111 same cycle -> OPEN, fail_cnt=0; cam_done+press same cycle in CAM -> no GUI.
//  Abort: KEY0=0 at cycle 4 of OPEN -> motor_open=0 next edge, state 0; events during LOCKOUT ignored.

Source files
------------

// File: rtl/access_sequencer.sv
// Security-system sequencer: selects the VGA source, gates the door motor and
// enforces a lockout after repeated failed camera/PIN attempts.
module access_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned OPEN_CYCLES     = 250_000_000,
  parameter int unsigned LOCK_CYCLES     = 1_500_000_000,
  parameter int unsigned MAX_FAILS       = 3
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        gui_req_n,
  input  logic        unlock,
  input  logic        cam_done,
  input  logic [31:0] ts_cmd,
  output logic        gui_select,
  output logic        motor_open,
  output logic        lockout,
  output logic [2:0]  fail_cnt,
  output logic [2:0]  state_code,
  output logic [2:0]  in_c_sig
);

  localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned DW      = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_CAM  = 3'd0,
    ST_GUI  = 3'd1,
    ST_OPEN = 3'd2,
    ST_LOCK = 3'd3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_tmr;
  logic            r_req_s1, r_req_s2, r_db, r_press;
  logic [DW-1:0]   r_db_cnt;
  logic            r_cam_prev, r_evt_cam, r_evt_unlock;
  logic [2:0]      r_ts_prev, r_evt_ts;
  logic [2:0]      w_fail_inc;
  logic            w_fail_max;
  logic            w_unused_ts;

  assign w_unused_ts = ^{ts_cmd[31:7], ts_cmd[3:0]};

  // Button sync + debounce; sync chain idles at the released (high) level.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_req_s1 <= 1'b1;
      r_req_s2 <= 1'b1;
      r_db     <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_req_s1 <= gui_req_n;
      r_req_s2 <= r_req_s1;
      r_press  <= 1'b0;
      if (r_req_s2 == r_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_db     <= r_req_s2;
        r_db_cnt <= '0;
        r_press  <= ~r_req_s2;
      end else begin
        r_db_cnt <= r_db_cnt + DW'(1);
      end
    end
  end

  // Rising-edge events, registered so they act one cycle after sampling.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_cam_prev   <= 1'b0;
      r_evt_cam    <= 1'b0;
      r_evt_unlock <= 1'b0;
      r_ts_prev    <= 3'd0;
      r_evt_ts     <= 3'd0;
    end else begin
      r_cam_prev   <= cam_done;
      r_evt_cam    <= cam_done & ~r_cam_prev;
      r_evt_unlock <= unlock;
      r_ts_prev    <= ts_cmd[6:4];
      r_evt_ts     <= ts_cmd[6:4] & ~r_ts_prev;
    end
  end

  assign w_fail_inc = (fail_cnt < 3'(MAX_FAILS)) ? fail_cnt + 3'd1 : fail_cnt;
  assign w_fail_max = (w_fail_inc == 3'(MAX_FAILS));

  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      r_state    <= ST_CAM;
      r_tmr      <= '0;
      gui_select <= 1'b0;
      motor_open <= 1'b0;
      lockout    <= 1'b0;
      fail_cnt   <= 3'd0;
    end else begin
      case (r_state)
        ST_CAM: begin
          gui_select <= 1'b0;
          motor_open <= 1'b0;
          lockout    <= 1'b0;
          if (r_evt_cam) begin
            if (r_evt_unlock) begin
              r_state    <= ST_OPEN;
              r_tmr      <= TW'(OPEN_CYCLES - 1);
              motor_open <= 1'b1;
              fail_cnt   <= 3'd0;
            end else begin
              fail_cnt <= w_fail_inc;
              if (w_fail_max) begin
                r_state <= ST_LOCK;
                r_tmr   <= TW'(LOCK_CYCLES - 1);
                lockout <= 1'b1;
              end
            end
          end else if (r_press) begin
            r_state    <= ST_GUI;
            gui_select <= 1'b1;
          end
        end
        ST_GUI: begin
          if (r_evt_ts[1]) begin
            r_state    <= ST_OPEN;
            r_tmr      <= TW'(OPEN_CYCLES - 1);
            motor_open <= 1'b1;
            gui_select <= 1'b0;
            fail_cnt   <= 3'd0;
          end else if (r_evt_ts[2]) begin
            fail_cnt <= w_fail_inc;
            if (w_fail_max) begin
              r_state    <= ST_LOCK;
              r_tmr      <= TW'(LOCK_CYCLES - 1);
              lockout    <= 1'b1;
              gui_select <= 1'b0;
            end
          end else if (r_evt_ts[0]) begin
            r_state    <= ST_CAM;
            gui_select <= 1'b0;
          end
        end
        ST_OPEN: begin
          if (r_tmr == '0) begin
            r_state    <= ST_CAM;
            motor_open <= 1'b0;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        ST_LOCK: begin
          if (r_tmr == '0) begin
            r_state  <= ST_CAM;
            lockout  <= 1'b0;
            fail_cnt <= 3'd0;
          end else begin
            r_tmr <= r_tmr - TW'(1);
          end
        end
        default: begin
          r_state    <= ST_CAM;
          gui_select <= 1'b0;
          motor_open <= 1'b0;
          lockout    <= 1'b0;
        end
      endcase
    end
  end

  assign state_code = r_state;
  assign in_c_sig   = {cam_done, unlock, gui_select};

endmodule

// File: tb/tb_access_sequencer.sv
// Bench for access_sequencer: directed scenarios plus random attempt sequences
// scored against a transaction-level model of the access policy.
module tb_access_sequencer;

  localparam int unsigned DEB  = 4;
  localparam int unsigned OPEN = 8;
  localparam int unsigned LOCK = 16;
  localparam int unsigned MAXF = 3;
  localparam int          WIN  = 32;

  localparam int M_CAM = 0;
  localparam int M_GUI = 1;

  logic        clk, key0, gui_req_n, unlock, cam_done;
  logic [31:0] ts_cmd;
  logic        gui_select, motor_open, lockout;
  logic [2:0]  fail_cnt, state_code, in_c_sig;

  int n_chk  = 0;
  int n_pass = 0;

  // Per-transaction observation counters.
  int g_motor, g_lock, g_fail_lk;

  // Policy model.
  int m_state = M_CAM;
  int m_fail  = 0;

  access_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .OPEN_CYCLES(OPEN), .LOCK_CYCLES(LOCK), .MAX_FAILS(MAXF)
  ) dut (
    .CLOCK_50(clk), .KEY0(key0), .gui_req_n(gui_req_n), .unlock(unlock),
    .cam_done(cam_done), .ts_cmd(ts_cmd), .gui_select(gui_select),
    .motor_open(motor_open), .lockout(lockout), .fail_cnt(fail_cnt),
    .state_code(state_code), .in_c_sig(in_c_sig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    if (motor_open) g_motor++;
    if (lockout) begin
      if (g_lock == 0) g_fail_lk = int'(fail_cnt);
      g_lock++;
    end
  endtask

  task automatic clear_obs();
    g_motor = 0; g_lock = 0; g_fail_lk = -1;
  endtask

  task automatic pulse_cam(input logic ok);
    unlock = ok; cam_done = 1'b1;
    step();
    cam_done = 1'b0; unlock = 1'($urandom);
  endtask

  task automatic pulse_ts(input logic [2:0] bits);
    ts_cmd[6:4] = bits;
    step();
    ts_cmd[6:4] = 3'b000;
  endtask

  task automatic hold_button(input int n);
    gui_req_n = 1'b0;
    repeat (n) step();
    gui_req_n = 1'b1;
  endtask

  // Model: update policy state for one attempt, return expected motor/lockout cycles.
  task automatic model_op(input int op, output int e_motor, output int e_lock);
    e_motor = 0; e_lock = 0;
    if (m_state == M_CAM) begin
      case (op)
        0: begin e_motor = OPEN; m_fail = 0; end
        1: begin
          m_fail++;
          if (m_fail == MAXF) begin e_lock = LOCK; m_fail = 0; end
        end
        2: m_state = M_GUI;
        default: ;
      endcase
    end else begin
      case (op)
        3: m_state = M_CAM;
        4, 6: begin e_motor = OPEN; m_fail = 0; m_state = M_CAM; end
        5: begin
          m_fail++;
          if (m_fail == MAXF) begin e_lock = LOCK; m_fail = 0; m_state = M_CAM; end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_after(input string tag, input int e_motor, input int e_lock);
    check_eq({tag, "_motor_cycles"}, g_motor, e_motor);
    check_eq({tag, "_lock_cycles"}, g_lock, e_lock);
    if (e_lock != 0) check_eq({tag, "_fail_at_lock"}, g_fail_lk, MAXF);
    check_eq({tag, "_state"}, state_code, m_state);
    check_eq({tag, "_fail"}, fail_cnt, m_fail);
    check_eq({tag, "_gui_sel"}, gui_select, (m_state == M_GUI) ? 1 : 0);
  endtask

  // ops: 0 cam ok, 1 cam fail, 2 press, 3 ts exit, 4 PIN ok, 5 PIN bad, 6 ts all three, 7 glitch
  task automatic do_op(input string tag, input int op);
    int e_motor, e_lock;
    model_op(op, e_motor, e_lock);
    clear_obs();
    ts_cmd = $urandom & ~32'h70;
    case (op)
      0: pulse_cam(1'b1);
      1: pulse_cam(1'b0);
      2: hold_button(6);
      3: pulse_ts(3'b001);
      4: pulse_ts(3'b010);
      5: pulse_ts(3'b100);
      6: pulse_ts(3'b111);
      default: hold_button(2);
    endcase
    repeat (WIN) step();
    check_after(tag, e_motor, e_lock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int k, dummy_m, dummy_l;
    key0 = 1'b0; gui_req_n = 1'b1; unlock = 1'b0; cam_done = 1'b0; ts_cmd = '0;
    clear_obs();
    repeat (3) @(negedge clk);
    check_eq("rst_gui_sel", gui_select, 0);
    check_eq("rst_motor", motor_open, 0);
    check_eq("rst_lockout", lockout, 0);
    check_eq("rst_fail", fail_cnt, 0);
    check_eq("rst_state", state_code, 0);
    cam_done = 1'b1; #1;
    check_eq("in_c_sig_cam", in_c_sig, 3'b100);
    cam_done = 1'b0; unlock = 1'b1; #1;
    check_eq("in_c_sig_unlock", in_c_sig, 3'b010);
    unlock = 1'b0;
    @(negedge clk);
    key0 = 1'b1;
    repeat (2) @(negedge clk);

    do_op("grant", 0);
    do_op("fail1", 1);
    do_op("fail2", 1);
    do_op("fail3_lock", 1);
    do_op("glitch_cam", 7);
    do_op("press", 2);
    do_op("cam_in_gui", 0);
    do_op("exit_gui", 3);
    do_op("press2", 2);
    do_op("pin_bad", 5);
    do_op("pin_prio", 6);
    do_op("ts_in_cam", 4);

    // cam_done edge and debounced press reach the sequencer together: cam wins.
    model_op(1, dummy_m, dummy_l);
    clear_obs();
    gui_req_n = 1'b0;
    repeat (5) step();
    unlock = 1'b0; cam_done = 1'b1;
    step();
    cam_done = 1'b0; gui_req_n = 1'b1;
    repeat (WIN) step();
    check_after("cam_vs_press", 0, 0);

    // Reset in the fourth cycle of a grant aborts the motor at once.
    clear_obs();
    pulse_cam(1'b1);
    k = 0;
    while (!motor_open && k < 10) begin step(); k++; end
    check_eq("abort_motor_rise", motor_open, 1);
    repeat (3) step();
    key0 = 1'b0;
    @(negedge clk);
    check_eq("abort_motor", motor_open, 0);
    check_eq("abort_state", state_code, 0);
    check_eq("abort_fail", fail_cnt, 0);
    key0 = 1'b1;
    m_state = M_CAM; m_fail = 0;
    repeat (4) @(negedge clk);

    // Events arriving during lockout are dropped, not queued.
    do_op("pre_lock1", 1);
    do_op("pre_lock2", 1);
    model_op(1, dummy_m, dummy_l);
    clear_obs();
    pulse_cam(1'b0);
    repeat (3) step();
    pulse_cam(1'b1);
    pulse_ts(3'b010);
    hold_button(6);
    repeat (WIN) step();
    check_after("lock_ignore", 0, LOCK);

    for (int i = 0; i < 60; i++) begin
      do_op($sformatf("rnd%0d", i), int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
